nbit_universal_shift_reg: RTL and testbench
===========================================

NBIT_UNIVERSAL_SHIFT_REG -- requirements
Module: nbit_universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), width of the shift-amount port.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  operation enable; when low, op is ignored (serializer still runs).
REQ-006 SHALL have port op  input  3  operation select (see REQ-010).
REQ-007 SHALL have port shamt  input  SHW  shift/rotate amount for ops 001..101.
REQ-008 SHALL have port din  input  WIDTH  parallel load / serializer load data.
REQ-009 SHALL have ports sin (input, 1, serial-in bit), dout (output, WIDTH, register contents), sout (output, 1, serial-out bit), sout_valid (output, 1, sout qualifier), word_valid (output, 1, deserialized word ready pulse), busy (output, 1, serializer active), done (output, 1, serializer-complete pulse).

Function
REQ-010 SHALL decode op when en=1 and busy=0: 000 hold; 001 logical left by shamt, zero fill; 010 logical right by shamt, zero fill; 011 rotate left by shamt; 100 rotate right by shamt; 101 arithmetic right by shamt, MSB fill; 110 serial shift-in; 111 parallel load and start serialize.
REQ-011 SHALL treat shamt=0 as no change for ops 001..101.
REQ-012 SHALL produce all-zero for ops 001/010 when shamt>=WIDTH, and all-MSB for op 101 when shamt>=WIDTH.
REQ-013 SHALL rotate by (shamt mod WIDTH) for ops 011/100, including non-power-of-2 WIDTH.
REQ-014 SHALL drive dout = internal register q combinationally, with no added latency; op results visible on dout the cycle after the edge.
REQ-015 SHALL, on op 110, perform q <= {q[WIDTH-2:0], sin} and increment a bit counter (0..WIDTH-1).
REQ-016 SHALL pulse word_valid for exactly one cycle, coincident with dout holding the completed word, when the WIDTH-th bit is shifted in, and wrap the bit counter to 0.
REQ-017 SHALL clear the bit counter on any op other than 000 or 110 and on serializer start.
REQ-018 SHALL implement a serializer FSM with states IDLE, SHIFT, FINISH.
REQ-019 SHALL, in IDLE, on en=1 and op=111, load q <= din, load a down-counter with WIDTH, and enter SHIFT.
REQ-020 SHALL, in SHIFT, drive sout = q[WIDTH-1] and sout_valid=1, then each cycle shift q left by 1 with zero fill and decrement the counter; on counter reaching 1 the transition is to FINISH, giving exactly WIDTH sout_valid cycles, MSB first.
REQ-021 SHALL, in FINISH, assert done for one cycle and return to IDLE; q SHALL then be all-zero.
REQ-022 SHALL hold busy=1 in SHIFT and FINISH, 0 in IDLE.
REQ-023 SHALL ignore en/op while busy=1 (no load, no shift, no restart); an op=111 issued in the FINISH cycle is also ignored.
REQ-024 SHALL accept a new op=111 in the first IDLE cycle after FINISH.
REQ-025 SHALL drive sout=0 and sout_valid=0 whenever not in SHIFT.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-serialization, immediately set q=0, FSM=IDLE, both counters=0, dout=0, sout=0, sout_valid=0, word_valid=0, busy=0, done=0.
REQ-027 SHALL, on rst deassertion, accept an op on the first subsequent rising edge with rst=0.

Verification
REQ-028 WIDTH=8: load 8'hB4 (op 111 ignored; use sequence load via op 111 then reset-free observation) -- instead: directed ops on q=8'hB4: shamt=3 op 001 -> 8'hA0; op 010 -> 8'h16; op 011 -> 8'hA5; op 100 -> 8'h96; op 101 -> 8'hF6.
REQ-029 WIDTH=6, q=6'b100110: op 011 shamt=7 -> 6'b001101; op 001 shamt=6 -> 6'b000000; op 101 shamt=7 -> 6'b111111.
REQ-030 WIDTH=8: op 110 with sin = 1,0,1,1,0,0,1,0 over 8 enabled cycles -> dout=8'hB2, word_valid high only on the 8th result cycle.
REQ-031 WIDTH=8: op 111 din=8'hC3 -> sout = 1,1,0,0,0,0,1,1 over 8 sout_valid cycles, done pulse next cycle, busy high for 9 cycles; op 001 applied during busy has no effect.
REQ-032 Assert rst asynchronously during 4th serialized bit -> all outputs 0 before next clk edge, FSM IDLE; new op 111 after release serializes the full new word.

Source files
------------

// File: rtl/nbit_universal_shift_reg.sv
// N-bit universal shift register: shifts, rotates, serial deserializer and an
// MSB-first parallel-to-serial engine sharing one storage register.
module nbit_universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   op_res_s;
  logic [SHW-1:0]     bcnt_r;
  logic [CW-1:0]      scnt_r;
  logic               word_valid_r;
  logic [SHW-1:0]     rot_s;
  logic [2*WIDTH-1:0] rol_s;
  logic [2*WIDTH-1:0] ror_s;
  logic               busy_s;
  logic               done_s;
  logic               sout_s;
  logic               sout_valid_s;

  // Rotation distance reduced modulo WIDTH; shifting the doubled word keeps
  // non-power-of-two widths correct.
  assign rot_s = SHW'(shamt % WIDTH);
  assign rol_s = {q_r, q_r} << rot_s;
  assign ror_s = {q_r, q_r} >> rot_s;

  // Result of the currently selected operation applied to the register
  always_comb begin
    op_res_s = q_r;
    case (op)
      3'b000:  op_res_s = q_r;
      3'b001:  op_res_s = q_r << shamt;
      3'b010:  op_res_s = q_r >> shamt;
      3'b011:  op_res_s = rol_s[2*WIDTH-1:WIDTH];
      3'b100:  op_res_s = ror_s[WIDTH-1:0];
      3'b101:  op_res_s = $signed(q_r) >>> shamt;
      3'b110:  op_res_s = {q_r[WIDTH-2:0], sin};
      3'b111:  op_res_s = din;
      default: op_res_s = q_r;
    endcase
  end

  // Serializer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Serializer next-state logic; ops are only honoured from IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (en && (op == 3'b111)) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (scnt_r == CW'(1)) begin
          state_nxt_s = FINISH;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Serializer outputs, decoded straight from the state and register
  always_comb begin
    busy_s       = 1'b0;
    done_s       = 1'b0;
    sout_s       = 1'b0;
    sout_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      SHIFT: begin
        busy_s       = 1'b1;
        sout_s       = q_r[WIDTH-1];
        sout_valid_s = 1'b1;
      end
      FINISH: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Register, bit counter and serializer down-counter update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r          <= '0;
      bcnt_r       <= '0;
      scnt_r       <= '0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (en) begin
            q_r <= op_res_s;
            case (op)
              3'b000: bcnt_r <= bcnt_r;
              3'b110: begin
                if (bcnt_r == SHW'(WIDTH - 1)) begin
                  bcnt_r       <= '0;
                  word_valid_r <= 1'b1;
                end else begin
                  bcnt_r <= bcnt_r + SHW'(1);
                end
              end
              3'b111: begin
                bcnt_r <= '0;
                scnt_r <= CW'(WIDTH);
              end
              default: bcnt_r <= '0;
            endcase
          end
        end
        SHIFT: begin
          q_r    <= {q_r[WIDTH-2:0], 1'b0};
          scnt_r <= scnt_r - CW'(1);
        end
        FINISH: begin
          q_r <= q_r;
        end
        default: begin
          q_r <= q_r;
        end
      endcase
    end
  end

  assign dout       = q_r;
  assign word_valid = word_valid_r;
  assign busy       = busy_s;
  assign done       = done_s;
  assign sout       = sout_s;
  assign sout_valid = sout_valid_s;

endmodule

// File: tb/tb_nbit_universal_shift_reg.sv
// Directed bench for nbit_universal_shift_reg: an 8-bit and a 6-bit instance
// driven by a linear sequence of ops with hand-computed expectations.
module tb_nbit_universal_shift_reg;

  logic       clk;
  logic       rst;
  int         checks;
  int         errors;

  logic       en8, sin8;
  logic [2:0] op8, shamt8;
  logic [7:0] din8, dout8;
  logic       sout8, sout_valid8, word_valid8, busy8, done8;

  logic       en6, sin6;
  logic [2:0] op6, shamt6;
  logic [5:0] din6, dout6;
  logic       sout6, sout_valid6, word_valid6, busy6, done6;

  nbit_universal_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .op(op8), .shamt(shamt8), .din(din8),
    .sin(sin8), .dout(dout8), .sout(sout8), .sout_valid(sout_valid8),
    .word_valid(word_valid8), .busy(busy8), .done(done8)
  );

  nbit_universal_shift_reg #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .en(en6), .op(op6), .shamt(shamt6), .din(din6),
    .sin(sin6), .dout(dout6), .sout(sout6), .sout_valid(sout_valid6),
    .word_valid(word_valid6), .busy(busy6), .done(done6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shin8(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      en8 = 1'b1; op8 = 3'b110; sin8 = v[i];
      @(posedge clk); #1;
    end
    en8 = 1'b0; op8 = 3'b000;
  endtask

  task automatic shin6(input logic [5:0] v);
    for (int i = 5; i >= 0; i--) begin
      en6 = 1'b1; op6 = 3'b110; sin6 = v[i];
      @(posedge clk); #1;
    end
    en6 = 1'b0; op6 = 3'b000;
  endtask

  task automatic do8(input logic [2:0] o, input logic [2:0] s);
    en8 = 1'b1; op8 = o; shamt8 = s;
    @(posedge clk); #1;
    en8 = 1'b0; op8 = 3'b000;
  endtask

  task automatic do6(input logic [2:0] o, input logic [2:0] s);
    en6 = 1'b1; op6 = o; shamt6 = s;
    @(posedge clk); #1;
    en6 = 1'b0; op6 = 3'b000;
  endtask

  // Called one cycle after the load edge; walks SHIFT and checks FINISH.
  task automatic ser_check(input string tag, input logic [7:0] w);
    logic [7:0] exp_q;
    for (int i = 0; i < 8; i++) begin
      exp_q = w << i;
      chk({tag, "_sout"}, sout8, w[7-i]);
      chk({tag, "_sout_valid"}, sout_valid8, 1'b1);
      chk({tag, "_busy"}, busy8, 1'b1);
      chk({tag, "_done_low"}, done8, 1'b0);
      chk({tag, "_q"}, dout8, exp_q);
      @(posedge clk); #1;
    end
    chk({tag, "_fin_done"}, done8, 1'b1);
    chk({tag, "_fin_busy"}, busy8, 1'b1);
    chk({tag, "_fin_sout_valid"}, sout_valid8, 1'b0);
    chk({tag, "_fin_sout"}, sout8, 1'b0);
    chk({tag, "_fin_q"}, dout8, 8'h00);
  endtask

  initial begin
    logic [7:0] b2;
    clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
    en8 = 1'b0; op8 = 3'b000; shamt8 = 3'd0; din8 = 8'h00; sin8 = 1'b0;
    en6 = 1'b0; op6 = 3'b000; shamt6 = 3'd0; din6 = 6'h00; sin6 = 1'b0;
    #12;
    chk("rst_dout", dout8, 8'h00);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_sout_valid", sout_valid8, 1'b0);
    chk("rst_word_valid", word_valid8, 1'b0);
    chk("rst_done", done8, 1'b0);
    rst = 1'b0;

    // Shift/rotate ops on 8'hB4
    shin8(8'hB4);
    chk("load_b4", dout8, 8'hB4);
    chk("load_b4_wv", word_valid8, 1'b1);
    do8(3'b001, 3'd3); chk("shl3", dout8, 8'hA0);
    shin8(8'hB4); do8(3'b010, 3'd3); chk("shr3", dout8, 8'h16);
    shin8(8'hB4); do8(3'b011, 3'd3); chk("rol3", dout8, 8'hA5);
    shin8(8'hB4); do8(3'b100, 3'd3); chk("ror3", dout8, 8'h96);
    shin8(8'hB4); do8(3'b101, 3'd3); chk("sra3", dout8, 8'hF6);
    do8(3'b001, 3'd0); chk("shl0_nochange", dout8, 8'hF6);
    en8 = 1'b0; op8 = 3'b001; shamt8 = 3'd2;
    @(posedge clk); #1;
    chk("en_low_ignored", dout8, 8'hF6);
    do8(3'b000, 3'd5); chk("hold", dout8, 8'hF6);

    // Width 6: rotate modulo, over-range shifts
    shin6(6'b100110); chk("w6_load", dout6, 6'b100110);
    do6(3'b011, 3'd7); chk("w6_rol7", dout6, 6'b001101);
    shin6(6'b100110); do6(3'b100, 3'd7); chk("w6_ror7", dout6, 6'b010011);
    shin6(6'b100110); do6(3'b001, 3'd6); chk("w6_shl6", dout6, 6'b000000);
    shin6(6'b100110); do6(3'b010, 3'd7); chk("w6_shr7", dout6, 6'b000000);
    shin6(6'b100110); do6(3'b101, 3'd7); chk("w6_sra7", dout6, 6'b111111);

    // Deserializer: 1,0,1,1,0,0,1,0 -> 8'hB2, word_valid only on 8th
    b2 = 8'hB2;
    for (int i = 0; i < 8; i++) begin
      en8 = 1'b1; op8 = 3'b110; sin8 = b2[7-i];
      @(posedge clk); #1;
      chk("deser_wv", word_valid8, (i == 7) ? 1'b1 : 1'b0);
    end
    chk("deser_word", dout8, 8'hB2);
    en8 = 1'b0; op8 = 3'b000;
    @(posedge clk); #1;
    chk("deser_wv_pulse_end", word_valid8, 1'b0);

    // Serializer C3, with op 001 applied while busy
    en8 = 1'b1; op8 = 3'b111; din8 = 8'hC3;
    @(posedge clk); #1;
    op8 = 3'b001; shamt8 = 3'd1;
    ser_check("ser_c3", 8'hC3);
    op8 = 3'b111; din8 = 8'hFF;
    @(posedge clk); #1;
    chk("fin_op111_ignored_busy", busy8, 1'b0);
    chk("fin_op111_ignored_q", dout8, 8'h00);
    chk("idle_done_low", done8, 1'b0);

    // Immediate restart, then async reset during 4th bit
    din8 = 8'h5A;
    @(posedge clk); #1;
    chk("restart_busy", busy8, 1'b1);
    chk("restart_bit0", sout8, 1'b0);
    @(posedge clk); #1; chk("restart_bit1", sout8, 1'b1);
    @(posedge clk); #1; chk("restart_bit2", sout8, 1'b0);
    @(posedge clk); #1; chk("restart_bit3", sout8, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout", dout8, 8'h00);
    chk("arst_sout", sout8, 1'b0);
    chk("arst_sout_valid", sout_valid8, 1'b0);
    chk("arst_busy", busy8, 1'b0);
    chk("arst_done", done8, 1'b0);
    chk("arst_word_valid", word_valid8, 1'b0);
    din8 = 8'h96;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    en8 = 1'b0; op8 = 3'b000;
    ser_check("ser_96", 8'h96);
    @(posedge clk); #1;
    chk("ser_96_idle", busy8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
